// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reduction modulo Q (ML-KEM, Q = 3329).
// Accepts the 32-bit product from the upstream multiplier and returns the
// canonical residue of its low K bits, with a sideband tag kept aligned and
// an overflow flag raised when any bit above K was set.
// Valid/ready on both sides; the whole pipe advances together on 'adv'.

module barrett_reduce_pipe #(
    parameter int Q     = 3329,
    parameter int K     = 24,
    parameter int M     = 5039,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    // Width of the Barrett constant, the full product and the partial remainder.
    // r = x - floor(x*M / 2^K)*Q is always below 2Q, which fits in RW bits.
    localparam int MW = $clog2(M + 1);
    localparam int PW = K + MW;
    localparam int RW = 14;

    localparam logic [PW-1:0] M_EXT = PW'(M);
    localparam logic [K-1:0]  Q_K   = K'(Q);
    localparam logic [RW-1:0] Q_R   = RW'(Q);

    // Pipeline advance: the tail is empty or is being drained this cycle.
    logic adv;

    // Stage valid bits
    logic v1, v2, v3;

    // Stage 1 registers: operand, full product, tag, overflow
    logic [K-1:0]     x1;
    logic [PW-1:0]    p1;
    logic [TAG_W-1:0] tag1;
    logic             ovf1;

    // Stage 2 registers: partial remainder in [0, 2Q)
    logic [RW-1:0]    r2;
    logic [TAG_W-1:0] tag2;
    logic             ovf2;

    // Stage 3 registers: canonical residue
    logic [11:0]      d3;
    logic [TAG_W-1:0] tag3;
    logic             ovf3;

    // Combinational stage inputs
    logic [K-1:0]  s1_x;
    logic [PW-1:0] s1_p;
    logic          s1_ovf;
    logic [MW-1:0] s2_t;
    logic [K-1:0]  s2_tq;
    logic [RW-1:0] s2_r;
    logic [11:0]   s3_d;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign out_data  = d3;
    assign out_tag   = tag3;
    assign out_ovf   = ovf3;

    // Per-stage arithmetic: product, quotient estimate and remainder, final correction
    always_comb begin
        s1_x   = in_data[K-1:0];
        s1_ovf = |in_data[31:K];
        s1_p   = PW'(s1_x) * M_EXT;
        s2_t   = MW'(p1 >> K);
        s2_tq  = K'(s2_t) * Q_K;
        s2_r   = RW'(x1 - s2_tq);
        s3_d   = (r2 >= Q_R) ? 12'(r2 - Q_R) : 12'(r2);
    end

    // Valid bits shift together; a missing input enters as a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Stage 1 capture; data only loads for real samples so bubbles never carry unknowns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1   <= '0;
            p1   <= '0;
            tag1 <= '0;
            ovf1 <= 1'b0;
        end else if (adv && in_valid) begin
            x1   <= s1_x;
            p1   <= s1_p;
            tag1 <= in_tag;
            ovf1 <= s1_ovf;
        end
    end

    // Stage 2 capture of the partial remainder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2   <= '0;
            tag2 <= '0;
            ovf2 <= 1'b0;
        end else if (adv && v1) begin
            r2   <= s2_r;
            tag2 <= tag1;
            ovf2 <= ovf1;
        end
    end

    // Stage 3 capture of the corrected residue; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d3   <= '0;
            tag3 <= '0;
            ovf3 <= 1'b0;
        end else if (adv && v2) begin
            d3   <= s3_d;
            tag3 <= tag2;
            ovf3 <= ovf2;
        end
    end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe. Expected residues come from
// plain modular arithmetic on the input word; ordering is tracked with a queue.

module tb_barrett_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [7:0]  out_tag;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] d;
        logic [7:0]  t;
        logic        o;
    } exp_t;

    exp_t sb[$];

    barrett_reduce_pipe #(.Q(3329), .K(24), .M(5039), .TAG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Reference: residue of the low 24 bits, overflow if anything above them
    function automatic exp_t model(input bit [31:0] x, input bit [7:0] t);
        exp_t e;
        bit [31:0] low;
        low = x % 32'd16777216;
        e.d = 12'(low % 32'd3329);
        e.t = t;
        e.o = (x >= 32'd16777216);
        return e;
    endfunction

    task automatic test_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 12'd0 || out_tag !== 8'd0 || out_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_high: got v=%b d=%0d t=%0d o=%b, want all 0", out_valid, out_data, out_tag, out_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'd0) begin
            bad++;
            $display("[TB] FAIL reset_low: got rdy=%b v=%b d=%0d, want rdy=1 v=0 d=0", in_ready, out_valid, out_data);
        end
        // three samples in flight, then reset wipes them
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(100 + n);
            in_tag   = 8'(n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got out_valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_flush[%0d]: got out_valid=%b, want 0", n, out_valid);
            end
        end
    endtask

    task automatic test_directed;
        int vals[7];
        int exps[7];
        vals = '{0, 35, 3329, 3330, 6658, 11075584, 3328};
        exps = '{0, 35, 0, 1, 0, 1, 3328};
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (n < 7) begin
                in_valid = 1'b1;
                in_data  = 32'(vals[n]);
                in_tag   = 8'(n + 16);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            total++;
            if (n >= 3 && n < 10) begin
                if (out_valid !== 1'b1 || out_data !== 12'(exps[n-3]) || out_tag !== 8'(n + 13) || out_ovf !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL directed[%0d]: got v=%b d=%0d t=%0d o=%b, want v=1 d=%0d t=%0d o=0",
                             n - 3, out_valid, out_data, out_tag, out_ovf, exps[n-3], n + 13);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL directed_idle[%0d]: got out_valid=%b, want 0", n, out_valid);
            end
        end
    endtask

    task automatic test_overflow;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (n < 2);
            in_data   = (n == 0) ? 32'd28004154 : 32'd6;
            in_tag    = (n == 0) ? 8'd4 : 8'd5;
            #1;
            if (n == 3) begin
                total++;
                if (out_valid !== 1'b1 || out_ovf !== 1'b1 || out_data !== 12'd1550 || out_tag !== 8'd4) begin
                    bad++;
                    $display("[TB] FAIL ovf_set: got v=%b o=%b d=%0d t=%0d, want v=1 o=1 d=1550 t=4", out_valid, out_ovf, out_data, out_tag);
                end
            end
            if (n == 4) begin
                total++;
                if (out_valid !== 1'b1 || out_ovf !== 1'b0 || out_data !== 12'd6 || out_tag !== 8'd5) begin
                    bad++;
                    $display("[TB] FAIL ovf_clear: got v=%b o=%b d=%0d t=%0d, want v=1 o=0 d=6 t=5", out_valid, out_ovf, out_data, out_tag);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        int sent = 0;
        bit hold = 0;
        logic [11:0] hd;
        logic [7:0] ht;
        logic ho;
        bit [31:0] cur;
        exp_t e;
        sb.delete();
        cur = $urandom_range(0, 32'hFFFFFF);
        for (int cyc = 0; cyc < 60 && (sent < 10 || sb.size() > 0); cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 10);
            in_data   = cur;
            in_tag    = 8'(sent);
            out_ready = !(cyc >= 5 && cyc < 9);
            #1;
            if (hold) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht || out_ovf !== ho) begin
                    bad++;
                    $display("[TB] FAIL bp_stable: got v=%b d=%0d t=%0d o=%b, want v=1 d=%0d t=%0d o=%b",
                             out_valid, out_data, out_tag, out_ovf, hd, ht, ho);
                end
            end
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("[TB] FAIL bp_ready: got in_ready=%b, want %b (v=%b ordy=%b)", in_ready, !out_valid || out_ready, out_valid, out_ready);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(cur, 8'(sent)));
                sent++;
                cur = $urandom_range(0, 32'hFFFFFF);
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL bp_extra: got unexpected output t=%0d, want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_tag !== e.t || out_ovf !== e.o) begin
                        bad++;
                        $display("[TB] FAIL bp_data: got d=%0d t=%0d o=%b, want d=%0d t=%0d o=%b", out_data, out_tag, out_ovf, e.d, e.t, e.o);
                    end
                end
            end
            hold = out_valid && !out_ready;
            hd = out_data;
            ht = out_tag;
            ho = out_ovf;
        end
        in_valid = 1'b0;
        total++;
        if (sent != 10 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL bp_drain: got sent=%0d pending=%0d, want sent=10 pending=0", sent, sb.size());
        end
    endtask

    task automatic test_bubbles;
        int sent = 0;
        bit [31:0] cur;
        exp_t e;
        sb.delete();
        cur = $urandom_range(0, 32'hFFFFFF);
        for (int cyc = 0; cyc < 400 && (sent < 40 || sb.size() > 0); cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 40) && (cyc % 2 == 0);
            in_data   = cur;
            in_tag    = 8'(sent + 100);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(cur, 8'(sent + 100)));
                sent++;
                cur = $urandom_range(0, 32'hFFFFFF);
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL bub_extra: got unexpected output t=%0d, want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_tag !== e.t || out_ovf !== e.o) begin
                        bad++;
                        $display("[TB] FAIL bub_data: got d=%0d t=%0d o=%b, want d=%0d t=%0d o=%b", out_data, out_tag, out_ovf, e.d, e.t, e.o);
                    end
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (sent != 40 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL bub_drain: got sent=%0d pending=%0d, want sent=40 pending=0", sent, sb.size());
        end
    endtask

    task automatic test_random;
        int sent = 0;
        int nsamp = 3000;
        bit [31:0] cur;
        exp_t e;
        sb.delete();
        cur = 32'd16777215;
        for (int cyc = 0; cyc < 20000 && (sent < nsamp || sb.size() > 0); cyc++) begin
            @(negedge clk);
            in_valid  = (sent < nsamp) && ($urandom_range(0, 9) < 8);
            in_data   = cur;
            in_tag    = 8'(sent);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(cur, 8'(sent)));
                sent++;
                if ($urandom_range(0, 15) == 0) cur = $urandom();
                else cur = $urandom_range(0, 32'hFFFFFF);
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rnd_extra: got unexpected output t=%0d, want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_tag !== e.t || out_ovf !== e.o) begin
                        bad++;
                        $display("[TB] FAIL rnd_data: got d=%0d t=%0d o=%b, want d=%0d t=%0d o=%b", out_data, out_tag, out_ovf, e.d, e.t, e.o);
                    end
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (sent != nsamp || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL rnd_drain: got sent=%0d pending=%0d, want sent=%0d pending=0", sent, sb.size(), nsamp);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_back_pressure();
        test_bubbles();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
